regfile_wr_arbiter: RTL and testbench



---
 rtl/regfile_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 59 +++++
 rtl/regfile_wr_arbiter.sv | 131 +++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file definitions: register count, the PC register index and
// the write-address one-hot decoder.
package regfile_pkg;

    localparam int unsigned NREG   = 16;
    localparam logic [3:0]  REG_PC = 4'd15;

    // One-hot decode of a 4-bit register address.
    function automatic logic [NREG-1:0] onehot16(input logic [3:0] addr);
        logic [NREG-1:0] vec;
        vec       = '0;
        vec[addr] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter. The search starts one past the last granted index and
// the pointer only moves when the grant is actually taken.
module rr_arbiter #(
    parameter int unsigned N = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic                 taken,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx
);

    localparam int unsigned IdxW = $clog2(N);

    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [IdxW-1:0] cand_idx;
    int unsigned     cand;
    logic            found;

    // First requester at or after ptr (wrapping) wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned off = 0; off < N; off++) begin
            cand = 32'(ptr_q) + off;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = IdxW'(cand);
            if (!found && req[cand_idx]) begin
                found           = 1'b1;
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
            end
        end
    end

    // Next pointer is the index after the winner, modulo N.
    always_comb begin
        ptr_d = ptr_q;
        if (taken) begin
            ptr_d = (grant_idx == IdxW'(N - 1)) ? '0 : grant_idx + IdxW'(1);
        end
    end

    // Pointer register; requester 0 has priority out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register file write port among NREQ producers. Each producer has a
// one-entry holding buffer; a round-robin arbiter drains one buffer per cycle
// into a registered write stage. Writes to R15 are accepted and discarded.
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned W    = 32,
    parameter int unsigned NREQ = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [4*NREQ-1:0] req_addr,
    input  logic [W*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              RegWrite,
    output logic [3:0]        A3,
    output logic [W-1:0]      WD3,
    output logic [NREG-1:0]   pending_mask,
    output logic              r15_drop
);

    localparam int unsigned IdxW = $clog2(NREQ);

    logic [NREQ-1:0] full_q, full_d;
    logic [3:0]      addr_q [NREQ];
    logic [W-1:0]    data_q [NREQ];

    logic [NREQ-1:0] grant;
    logic [IdxW-1:0] grant_idx;
    logic            grant_any;
    logic [NREQ-1:0] accept;
    logic [NREQ-1:0] is_pc;
    logic [NREQ-1:0] load;

    logic            regwrite_q;
    logic [3:0]      a3_q;
    logic [W-1:0]    wd3_q;
    logic            r15_drop_q, r15_drop_d;
    logic [NREG-1:0] pend;

    rr_arbiter #(
        .N (NREQ)
    ) u_rr_arbiter (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (full_q),
        .taken     (grant_any),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign grant_any = |grant;

    // A buffer being drained this cycle can be refilled at the same edge.
    assign req_ready = rst_n ? (~full_q | grant) : '0;

    // Accept, R15 filtering and next full state per buffer.
    always_comb begin
        accept     = '0;
        is_pc      = '0;
        load       = '0;
        full_d     = '0;
        r15_drop_d = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            accept[i] = req_valid[i] & req_ready[i];
            is_pc[i]  = (req_addr[4*i +: 4] == REG_PC);
            load[i]   = accept[i] & ~is_pc[i];
            full_d[i] = load[i] | (full_q[i] & ~grant[i]);
        end
        // Several R15 writes in one cycle still give a single pulse.
        r15_drop_d = |(accept & is_pc);
    end

    // Holding buffers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= '0;
            for (int i = 0; i < NREQ; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            full_q <= full_d;
            for (int i = 0; i < NREQ; i++) begin
                if (load[i]) begin
                    addr_q[i] <= req_addr[4*i +: 4];
                    data_q[i] <= req_data[W*i +: W];
                end
            end
        end
    end

    // Issue register; A3/WD3 hold their last values when nothing is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regwrite_q <= 1'b0;
            a3_q       <= '0;
            wd3_q      <= '0;
            r15_drop_q <= 1'b0;
        end else begin
            regwrite_q <= grant_any;
            r15_drop_q <= r15_drop_d;
            if (grant_any) begin
                a3_q  <= addr_q[grant_idx];
                wd3_q <= data_q[grant_idx];
            end
        end
    end

    // Registers with a write buffered or in the issue stage.
    always_comb begin
        pend = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (full_q[i]) begin
                pend = pend | onehot16(addr_q[i]);
            end
        end
        if (regwrite_q) begin
            pend = pend | onehot16(a3_q);
        end
        pend[REG_PC] = 1'b0;
    end

    assign RegWrite     = regwrite_q;
    assign A3           = a3_q;
    assign WD3          = wd3_q;
    assign pending_mask = pend;
    assign r15_drop     = r15_drop_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter: a cycle-level behavioural model
// predicts grants and pushes expected writes; a negedge monitor compares.
module tb_regfile_wr_arbiter;

    localparam int unsigned W    = 32;
    localparam int unsigned NREQ = 3;

    localparam int MIdle = 0, MSingle = 1, MCont = 2, MStream = 3, MR15 = 4, MRand = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid;
    logic [4*NREQ-1:0] req_addr;
    logic [W*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              RegWrite;
    logic [3:0]        A3;
    logic [W-1:0]      WD3;
    logic [15:0]       pending_mask;
    logic              r15_drop;

    always #5 clk = ~clk;

    regfile_wr_arbiter #(
        .W    (W),
        .NREQ (NREQ)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .RegWrite     (RegWrite),
        .A3           (A3),
        .WD3          (WD3),
        .pending_mask (pending_mask),
        .r15_drop     (r15_drop)
    );

    typedef struct {
        logic [3:0]   a;
        logic [W-1:0] d;
    } wr_t;

    wr_t exp_q[$];

    // Reference model: one pending write per producer, next-search index,
    // and what the write port / drop pulse should show this cycle.
    bit           m_full [NREQ];
    logic [3:0]   m_addr [NREQ];
    logic [W-1:0] m_data [NREQ];
    int           m_ptr;
    bit           m_rw;
    logic [3:0]   m_a3;
    bit           m_drop;

    bit           cur_v [NREQ];
    logic [3:0]   cur_a [NREQ];
    logic [W-1:0] cur_d [NREQ];
    bit           acc   [NREQ];

    int n_vec, n_err;
    bit mon_en;
    int mode;
    int stream_n;
    bit shot_left;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pick();
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NREQ;
            if (m_full[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [15:0] model_mask();
        logic [15:0] m;
        m = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (m_full[i]) m = m | (16'h1 << m_addr[i]);
        end
        if (m_rw) m = m | (16'h1 << m_a3);
        return m;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NREQ; i++) begin
            m_full[i] = 0;
            m_addr[i] = '0;
            m_data[i] = '0;
            cur_v[i]  = 0;
            cur_a[i]  = '0;
            cur_d[i]  = '0;
            acc[i]    = 0;
        end
        m_ptr  = 0;
        m_rw   = 0;
        m_a3   = '0;
        m_drop = 0;
        exp_q.delete();
    endtask

    // Advance the model across one rising edge using the applied inputs.
    task automatic model_update();
        int  g;
        bit  rdy [NREQ];
        bit  drop;
        wr_t w;
        g = pick();
        for (int i = 0; i < NREQ; i++) rdy[i] = !m_full[i] || (g == i);
        if (g >= 0) begin
            w.a = m_addr[g];
            w.d = m_data[g];
            exp_q.push_back(w);
            m_rw      = 1;
            m_a3      = m_addr[g];
            m_full[g] = 0;
            m_ptr     = (g + 1) % NREQ;
        end else begin
            m_rw = 0;
        end
        drop = 0;
        for (int i = 0; i < NREQ; i++) begin
            acc[i] = cur_v[i] && rdy[i];
            if (acc[i]) begin
                if (cur_a[i] == 4'hF) begin
                    drop = 1;
                end else begin
                    m_full[i] = 1;
                    m_addr[i] = cur_a[i];
                    m_data[i] = cur_d[i];
                end
            end
        end
        m_drop = drop;
    endtask

    task automatic gen(input int i);
        cur_v[i] = 0;
        case (mode)
            MSingle: if (i == 0 && shot_left) begin
                cur_v[i] = 1; cur_a[i] = 4'd3; cur_d[i] = 32'hDEAD_BEEF; shot_left = 0;
            end
            MCont: begin
                cur_v[i] = 1;
                cur_a[i] = (i == 0) ? 4'd1 : (i == 1) ? 4'd2 : 4'd4;
                cur_d[i] = $urandom;
            end
            MStream: if (i == 2 && stream_n < 8) begin
                cur_v[i] = 1; cur_a[i] = 4'd5; cur_d[i] = W'(stream_n); stream_n++;
            end
            MR15: if (i == 1 && shot_left) begin
                cur_v[i] = 1; cur_a[i] = 4'hF; cur_d[i] = $urandom; shot_left = 0;
            end
            MRand: begin
                cur_v[i] = 1'($urandom_range(0, 1));
                cur_a[i] = 4'($urandom_range(0, 15));
                cur_d[i] = $urandom;
            end
            default: ;
        endcase
    endtask

    task automatic apply();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]       = cur_v[i];
            req_addr[4*i +: 4] = cur_a[i];
            req_data[W*i +: W] = cur_d[i];
        end
    endtask

    // One clock: model steps at the edge, then held requests stay, others renew.
    task automatic cycle();
        @(posedge clk);
        model_update();
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (!(cur_v[i] && !acc[i])) gen(i);
        end
        apply();
    endtask

    task automatic run(input int m, input int n);
        mode = m;
        repeat (n) cycle();
    endtask

    // Monitor: compare DUT outputs with the model and pop the scoreboard.
    always @(negedge clk) begin : monitor
        int          g;
        logic [2:0]  rdy;
        wr_t         w;
        if (mon_en) begin
            g = pick();
            for (int i = 0; i < NREQ; i++) rdy[i] = !m_full[i] || (g == i);
            check("req_ready", 32'(req_ready), 32'(rdy));
            check("pending_mask", 32'(pending_mask), 32'(model_mask()));
            check("RegWrite", 32'(RegWrite), 32'(m_rw));
            check("r15_drop", 32'(r15_drop), 32'(m_drop));
            if (RegWrite) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_write: got A3=%h WD3=%h, expected no write", A3, WD3);
                end else begin
                    w = exp_q.pop_front();
                    check("A3", 32'(A3), 32'(w.a));
                    check("WD3", WD3, w.d);
                end
            end
        end
    end

    initial begin
        n_vec     = 0;
        n_err     = 0;
        mon_en    = 0;
        mode      = MIdle;
        stream_n  = 0;
        shot_left = 0;
        model_clear();

        // Reset with every requester asserting valid.
        rst_n     = 1'b0;
        req_valid = '1;
        req_addr  = {4'd4, 4'd2, 4'd1};
        req_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_RegWrite", 32'(RegWrite), 32'h0);
        check("rst_pending_mask", 32'(pending_mask), 32'h0);
        check("rst_r15_drop", 32'(r15_drop), 32'h0);
        check("rst_A3", 32'(A3), 32'h0);
        check("rst_WD3", WD3, 32'h0);
        apply();
        #1;
        rst_n  = 1'b1;
        mon_en = 1;

        shot_left = 1;
        run(MSingle, 6);
        run(MCont, 12);
        run(MIdle, 6);
        stream_n = 0;
        run(MStream, 12);
        run(MIdle, 3);
        shot_left = 1;
        run(MR15, 5);
        run(MRand, 300);
        run(MIdle, 8);

        // Reset pulse between edges with all buffers busy.
        run(MCont, 5);
        #2;
        rst_n  = 1'b0;
        mon_en = 0;
        #1;
        check("midrst_RegWrite", 32'(RegWrite), 32'h0);
        check("midrst_pending_mask", 32'(pending_mask), 32'h0);
        check("midrst_req_ready", 32'(req_ready), 32'h0);
        model_clear();
        apply();
        mode = MIdle;
        @(posedge clk);
        @(negedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1;
        run(MIdle, 6);
        run(MRand, 40);
        run(MIdle, 8);

        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        mon_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
